// File: rtl/yc_timing_pkg.sv
// Timing constants and helpers shared by the Y/C raster sync generator.
// One timing_t record per supported TV standard (240p NTSC, 288p PAL).
package yc_timing_pkg;

    localparam int H_W = 11;
    localparam int V_W = 9;

    typedef struct packed {
        logic [H_W-1:0] h_total;
        logic [H_W-1:0] h_sync;
        logic [H_W-1:0] h_eq;
        logic [H_W-1:0] h_act_start;
        logic [H_W-1:0] h_active;
        logic [V_W-1:0] v_total;
        logic [V_W-1:0] v_act_start;
        logic [V_W-1:0] v_active;
        logic [6:0]     burst_start;
        logic [9:0]     burst_end;
    } timing_t;

    localparam timing_t NTSC_TIMING = '{
        h_total:     11'd1716,
        h_sync:      11'd127,
        h_eq:        11'd63,
        h_act_start: 11'd244,
        h_active:    11'd1440,
        v_total:     9'd262,
        v_act_start: 9'd21,
        v_active:    9'd240,
        burst_start: 7'd16,
        burst_end:   10'd84
    };

    localparam timing_t PAL_TIMING = '{
        h_total:     11'd1728,
        h_sync:      11'd127,
        h_eq:        11'd63,
        h_act_start: 11'd264,
        h_active:    11'd1440,
        v_total:     9'd312,
        v_act_start: 9'd23,
        v_active:    9'd288,
        burst_start: 7'd24,
        burst_end:   10'd85
    };

    function automatic logic [16:0] burst_word(input logic [6:0] burst_start,
                                               input logic [9:0] burst_end);
        return {burst_start, burst_end};
    endfunction

endpackage

// File: rtl/yc_sync_timing.sv
// Raster timing generator feeding the Y/C encoder: sync, blanking, active coordinates
// and burst window, with NTSC/PAL selection switched only on frame boundaries.
module yc_sync_timing
    import yc_timing_pkg::*;
#(
    parameter int X_W = 11,
    parameter int Y_W = 9
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           pal_en,
    output logic           hsync_o,
    output logic           vsync_o,
    output logic           csync_o,
    output logic           hblank_o,
    output logic           vblank_o,
    output logic           de_o,
    output logic [X_W-1:0] x_o,
    output logic [Y_W-1:0] y_o,
    output logic           frame_start_o,
    output logic           pal_o,
    output logic [16:0]    colorburst_range_o
);

    logic [H_W-1:0] h_cnt;
    logic [V_W-1:0] v_cnt;
    logic           pal_q;   // standard in effect for the counters; pal_o trails it by one

    timing_t        tm;
    logic [H_W-1:0] half;
    logic           h_last;
    logic           v_last;

    assign tm     = pal_q ? PAL_TIMING : NTSC_TIMING;
    assign half   = tm.h_total >> 1;
    assign h_last = (h_cnt == tm.h_total - 11'd1);
    assign v_last = (v_cnt == tm.v_total - 9'd1);

    logic           hsync_d;
    logic           vsync_d;
    logic           csync_d;
    logic           eq_line;
    logic           hblank_d;
    logic           vblank_d;
    logic           de_d;
    logic [X_W-1:0] x_d;
    logic [Y_W-1:0] y_d;
    logic           frame_start_d;

    // NOTE: every signal gets a default at the top of always_comb so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        hsync_d       = 1'b0;
        vsync_d       = 1'b0;
        csync_d       = 1'b0;
        eq_line       = 1'b0;
        hblank_d      = 1'b1;
        vblank_d      = 1'b1;
        de_d          = 1'b0;
        x_d           = '0;
        y_d           = '0;
        frame_start_d = 1'b0;

        hsync_d = (h_cnt < tm.h_sync);
        vsync_d = (v_cnt >= 9'd3) && (v_cnt <= 9'd5);
        eq_line = (v_cnt <= 9'd2) || ((v_cnt >= 9'd6) && (v_cnt <= 9'd8));

        // Equalising lines carry two narrow pulses; broad lines are serrated twice.
        if (eq_line) begin
            csync_d = (h_cnt < tm.h_eq) ||
                      ((h_cnt >= half) && (h_cnt < half + tm.h_eq));
        end else if (vsync_d) begin
            csync_d = !(((h_cnt >= half - tm.h_sync) && (h_cnt < half)) ||
                        (h_cnt >= tm.h_total - tm.h_sync));
        end else begin
            csync_d = hsync_d;
        end

        hblank_d = (h_cnt < tm.h_act_start) ||
                   (h_cnt >= tm.h_act_start + tm.h_active);
        vblank_d = (v_cnt < tm.v_act_start) ||
                   (v_cnt >= tm.v_act_start + tm.v_active);
        de_d     = !hblank_d && !vblank_d;

        if (de_d) begin
            x_d = X_W'(h_cnt - tm.h_act_start);
        end
        if (!vblank_d) begin
            y_d = Y_W'(v_cnt - tm.v_act_start);
        end

        frame_start_d = (h_cnt == '0) && (v_cnt == '0);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values and the block order cannot create accidental dependencies.
    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt              <= '0;
            v_cnt              <= '0;
            pal_q              <= 1'b0;
            hsync_o            <= 1'b0;
            vsync_o            <= 1'b0;
            csync_o            <= 1'b0;
            hblank_o           <= 1'b0;
            vblank_o           <= 1'b0;
            de_o               <= 1'b0;
            x_o                <= '0;
            y_o                <= '0;
            frame_start_o      <= 1'b0;
            pal_o              <= 1'b0;
            colorburst_range_o <= burst_word(NTSC_TIMING.burst_start, NTSC_TIMING.burst_end);
        end else begin
            if (h_last) begin
                h_cnt <= '0;
                if (v_last) begin
                    v_cnt <= '0;
                    pal_q <= pal_en;
                end else begin
                    v_cnt <= v_cnt + 9'd1;
                end
            end else begin
                h_cnt <= h_cnt + 11'd1;
            end

            hsync_o            <= hsync_d;
            vsync_o            <= vsync_d;
            csync_o            <= csync_d;
            hblank_o           <= hblank_d;
            vblank_o           <= vblank_d;
            de_o               <= de_d;
            x_o                <= x_d;
            y_o                <= y_d;
            frame_start_o      <= frame_start_d;
            pal_o              <= pal_q;
            colorburst_range_o <= burst_word(tm.burst_start, tm.burst_end);
        end
    end

endmodule
